// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: tracks ID..WB occupancy, selects IE
// operand forwarding, raises load-use/RAW stalls and branch flushes, and counts retirements.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_WIDTH   = 5,
  parameter int unsigned COMMIT_CNT_WIDTH = 32,
  parameter bit          FORWARDING_EN    = 1'b1
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic [REG_ADDR_WIDTH-1:0]   i_id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]   i_id_rs2,
  input  logic                        i_id_use_rs1,
  input  logic                        i_id_use_rs2,
  input  logic [REG_ADDR_WIDTH-1:0]   i_id_rd,
  input  logic                        i_id_reg_wr_en,
  input  logic                        i_id_is_load,
  input  logic                        i_ie_pc_sel,
  output logic                        o_stall_if,
  output logic                        o_stall_id,
  output logic                        o_flush_id,
  output logic                        o_flush_ie,
  output logic [1:0]                  o_fwd_a_sel,
  output logic [1:0]                  o_fwd_b_sel,
  output logic                        o_instr_commit,
  output logic [COMMIT_CNT_WIDTH-1:0] o_commit_count
);

  localparam int unsigned RA = REG_ADDR_WIDTH;
  localparam int unsigned CC = COMMIT_CNT_WIDTH;

  logic          id_valid_q, id_valid_d;
  logic          ie_valid_q, ie_valid_d;
  logic [RA-1:0] ie_rd_q, ie_rs1_q, ie_rs2_q;
  logic          ie_wr_en_q, ie_is_load_q, ie_use_rs1_q, ie_use_rs2_q;
  logic          im_valid_q, im_wr_en_q, im_is_load_q;
  logic [RA-1:0] im_rd_q;
  logic          wb_valid_q, wb_wr_en_q;
  logic [RA-1:0] wb_rd_q;
  logic          commit_q;
  logic [CC-1:0] count_q;

  logic hit_ie, hit_im, hit_wb, hazard, flush, stall;
  logic [1:0] fwd_a, fwd_b;

  // A producer stage feeds a consumer operand; x0 never matches.
  function automatic logic reg_match(input logic vld, input logic wr_en, input logic [RA-1:0] rd,
                                     input logic [RA-1:0] rs, input logic use_rs);
    return vld & wr_en & (rd == rs) & (rs != '0) & use_rs;
  endfunction

  // IM beats WB; a load still in IM has no data yet and is never a source.
  function automatic logic [1:0] fwd_src(input logic [RA-1:0] rs, input logic use_rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (FORWARDING_EN && ie_valid_q) begin
      if (reg_match(im_valid_q & ~im_is_load_q, im_wr_en_q, im_rd_q, rs, use_rs))
        sel = 2'b10;
      else if (reg_match(wb_valid_q, wb_wr_en_q, wb_rd_q, rs, use_rs))
        sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    hit_ie = reg_match(ie_valid_q, ie_wr_en_q, ie_rd_q, i_id_rs1, i_id_use_rs1) |
             reg_match(ie_valid_q, ie_wr_en_q, ie_rd_q, i_id_rs2, i_id_use_rs2);
    hit_im = reg_match(im_valid_q, im_wr_en_q, im_rd_q, i_id_rs1, i_id_use_rs1) |
             reg_match(im_valid_q, im_wr_en_q, im_rd_q, i_id_rs2, i_id_use_rs2);
    hit_wb = reg_match(wb_valid_q, wb_wr_en_q, wb_rd_q, i_id_rs1, i_id_use_rs1) |
             reg_match(wb_valid_q, wb_wr_en_q, wb_rd_q, i_id_rs2, i_id_use_rs2);
    if (FORWARDING_EN) hazard = id_valid_q & hit_ie & ie_is_load_q;
    else               hazard = id_valid_q & (hit_ie | hit_im | hit_wb);
    // A taken branch discards ID anyway, so it overrides any stall.
    flush = i_ie_pc_sel & ie_valid_q;
    stall = hazard & ~flush;
    fwd_a = fwd_src(ie_rs1_q, ie_use_rs1_q);
    fwd_b = fwd_src(ie_rs2_q, ie_use_rs2_q);
    id_valid_d = flush ? 1'b0 : (stall ? id_valid_q : 1'b1);
    ie_valid_d = id_valid_q & ~(flush | stall);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      id_valid_q   <= 1'b0;
      ie_valid_q   <= 1'b0;
      ie_rd_q      <= '0;
      ie_rs1_q     <= '0;
      ie_rs2_q     <= '0;
      ie_wr_en_q   <= 1'b0;
      ie_is_load_q <= 1'b0;
      ie_use_rs1_q <= 1'b0;
      ie_use_rs2_q <= 1'b0;
      im_valid_q   <= 1'b0;
      im_rd_q      <= '0;
      im_wr_en_q   <= 1'b0;
      im_is_load_q <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_wr_en_q   <= 1'b0;
      commit_q     <= 1'b0;
      count_q      <= '0;
    end else begin
      id_valid_q   <= id_valid_d;
      ie_valid_q   <= ie_valid_d;
      ie_rd_q      <= i_id_rd;
      ie_rs1_q     <= i_id_rs1;
      ie_rs2_q     <= i_id_rs2;
      ie_wr_en_q   <= i_id_reg_wr_en;
      ie_is_load_q <= i_id_is_load;
      ie_use_rs1_q <= i_id_use_rs1;
      ie_use_rs2_q <= i_id_use_rs2;
      im_valid_q   <= ie_valid_q;
      im_rd_q      <= ie_rd_q;
      im_wr_en_q   <= ie_wr_en_q;
      im_is_load_q <= ie_is_load_q;
      wb_valid_q   <= im_valid_q;
      wb_rd_q      <= im_rd_q;
      wb_wr_en_q   <= im_wr_en_q;
      commit_q     <= wb_valid_q;
      count_q      <= count_q + CC'(wb_valid_q);
    end
  end

  assign o_stall_if     = stall;
  assign o_stall_id     = stall;
  assign o_flush_id     = flush;
  assign o_flush_ie     = flush | stall;
  assign o_fwd_a_sel    = fwd_a;
  assign o_fwd_b_sel    = fwd_b;
  assign o_instr_commit = commit_q;
  assign o_commit_count = count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three instances (forwarding, no forwarding, 4-bit counter)
// driven in lockstep, checked every cycle against a per-instruction pipeline reference model.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic       wr;
    logic       ld;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
  } ins_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_u1, id_u2, id_wr, id_ld, pc_sel;

  logic        s_if [3];
  logic        s_id [3];
  logic        f_id [3];
  logic        f_ie [3];
  logic [1:0]  fa   [3];
  logic [1:0]  fb   [3];
  logic        cm   [3];
  logic [31:0] cnt32[3];

  logic        smp_sif[3], smp_sid[3], smp_fid[3], smp_fie[3], smp_cm[3];
  logic [1:0]  smp_fa[3], smp_fb[3];
  logic [31:0] smp_cnt[3];

  ins_t        stg   [3][3];
  logic        idv   [3];
  logic        mcm   [3];
  logic [31:0] mcnt  [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam bit          FE  = (g != 1);
    localparam int unsigned CCW = (g == 2) ? 4 : 32;
    logic [CCW-1:0] cnt;
    pipeline_hazard_ctrl #(
      .REG_ADDR_WIDTH(5), .COMMIT_CNT_WIDTH(CCW), .FORWARDING_EN(FE)
    ) u_dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(id_u1), .i_id_use_rs2(id_u2),
      .i_id_rd(id_rd), .i_id_reg_wr_en(id_wr), .i_id_is_load(id_ld), .i_ie_pc_sel(pc_sel),
      .o_stall_if(s_if[g]), .o_stall_id(s_id[g]), .o_flush_id(f_id[g]), .o_flush_ie(f_ie[g]),
      .o_fwd_a_sel(fa[g]), .o_fwd_b_sel(fb[g]), .o_instr_commit(cm[g]), .o_commit_count(cnt)
    );
    assign cnt32[g] = 32'(cnt);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Does an older instruction s produce a register that instruction c consumes?
  function automatic logic writes(input ins_t s, input logic [4:0] rs, input logic u);
    return s.v && s.wr && (s.rd == rs) && (rs != 5'd0) && u;
  endfunction

  function automatic logic feeds(input ins_t s, input ins_t c);
    return writes(s, c.rs1, c.u1) || writes(s, c.rs2, c.u2);
  endfunction

  // Where the IE consumer gets an operand: youngest non-load producer in IM, else WB.
  function automatic logic [1:0] src(input logic fe, input ins_t ie, input ins_t im,
                                     input ins_t wb, input logic [4:0] rs, input logic u);
    if (!fe || !ie.v) return 2'd0;
    if (writes(im, rs, u) && !im.ld) return 2'd2;
    if (writes(wb, rs, u)) return 2'd1;
    return 2'd0;
  endfunction

  task automatic set_id(input logic [4:0] rd, input logic wr, input logic ld,
                        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
    id_rd = rd; id_wr = wr; id_ld = ld;
    id_rs1 = rs1; id_u1 = u1; id_rs2 = rs2; id_u2 = u2;
  endtask

  task automatic cyc();
    ins_t        id;
    logic        fe, fl, hz, st, any;
    logic [31:0] mask;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      smp_sif[k] = s_if[k]; smp_sid[k] = s_id[k]; smp_fid[k] = f_id[k]; smp_fie[k] = f_ie[k];
      smp_fa[k] = fa[k]; smp_fb[k] = fb[k]; smp_cm[k] = cm[k]; smp_cnt[k] = cnt32[k];
      fe = (k != 1);
      id = '0;
      id.v = idv[k]; id.rd = id_rd; id.wr = id_wr; id.ld = id_ld;
      id.rs1 = id_rs1; id.rs2 = id_rs2; id.u1 = id_u1; id.u2 = id_u2;
      any = 1'b0;
      for (int j = 0; j < 3; j++) any |= feeds(stg[k][j], id);
      fl = pc_sel && stg[k][0].v;
      hz = idv[k] && (fe ? (feeds(stg[k][0], id) && stg[k][0].ld) : any);
      st = hz && !fl;
      chk($sformatf("d%0d_stall_if", k), 32'(smp_sif[k]), 32'(st));
      chk($sformatf("d%0d_stall_id", k), 32'(smp_sid[k]), 32'(st));
      chk($sformatf("d%0d_flush_id", k), 32'(smp_fid[k]), 32'(fl));
      chk($sformatf("d%0d_flush_ie", k), 32'(smp_fie[k]), 32'(fl || st));
      chk($sformatf("d%0d_fwd_a", k), 32'(smp_fa[k]),
          32'(src(fe, stg[k][0], stg[k][1], stg[k][2], stg[k][0].rs1, stg[k][0].u1)));
      chk($sformatf("d%0d_fwd_b", k), 32'(smp_fb[k]),
          32'(src(fe, stg[k][0], stg[k][1], stg[k][2], stg[k][0].rs2, stg[k][0].u2)));
      chk($sformatf("d%0d_commit", k), 32'(smp_cm[k]), 32'(mcm[k]));
      chk($sformatf("d%0d_count", k), smp_cnt[k], mcnt[k]);
      if (!rst_n) begin
        for (int j = 0; j < 3; j++) stg[k][j] = '0;
        idv[k] = 1'b0; mcm[k] = 1'b0; mcnt[k] = 32'd0;
      end else begin
        mask    = (k == 2) ? 32'hF : 32'hFFFF_FFFF;
        mcnt[k] = (mcnt[k] + 32'(stg[k][2].v)) & mask;
        mcm[k]  = stg[k][2].v;
        stg[k][2] = stg[k][1];
        stg[k][1] = stg[k][0];
        stg[k][0] = id;
        stg[k][0].v = idv[k] && !(fl || st);
        idv[k] = fl ? 1'b0 : (st ? idv[k] : 1'b1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    set_id(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    int first;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) stg[k][j] = '0;
      idv[k] = 1'b0; mcm[k] = 1'b0; mcnt[k] = 32'd0;
    end
    rst_n = 1'b0; pc_sel = 1'b0; nop();
    cyc(); cyc();

    // Independent ALU stream: latency to first commit and retired count.
    rst_n = 1'b1;
    cyc();
    first = -1;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) set_id(5'(i + 1), 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      else nop();
      cyc();
      if (smp_cm[0] && first < 0) first = i;
    end
    chk("t1_first_commit", 32'(first), 32'd4);
    chk("t1_count", smp_cnt[0], 32'd6);

    // add x5 followed by readers of x5, held for four cycles.
    set_id(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    set_id(5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    cyc(); chk("t4_raw_stall_1", 32'(smp_sif[1]), 32'd1);
    cyc(); chk("t4_raw_stall_2", 32'(smp_sif[1]), 32'd1);
           chk("t2_fwd_im", 32'(smp_fa[0]), 32'd2);
    cyc(); chk("t4_raw_stall_3", 32'(smp_sif[1]), 32'd1);
           chk("t2_fwd_wb", 32'(smp_fa[0]), 32'd1);
    cyc(); chk("t4_raw_released", 32'(smp_sif[1]), 32'd0);
           chk("t2_fwd_none", 32'(smp_fa[0]), 32'd0);

    // Writes to x0 are never a hazard or forwarding source.
    set_id(5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    set_id(5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
    cyc(); chk("t2_x0_nostall", 32'(smp_sif[1]), 32'd0);
    nop();
    cyc(); chk("t2_x0_fwd", 32'(smp_fa[0]), 32'd0);

    // Load-use on x7: one bubble, then the load value arrives via WB.
    set_id(5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    set_id(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    cyc(); chk("t3_stall_if", 32'(smp_sif[0]), 32'd1);
           chk("t3_stall_id", 32'(smp_sid[0]), 32'd1);
           chk("t3_flush_ie", 32'(smp_fie[0]), 32'd1);
    cyc(); chk("t3_one_cycle", 32'(smp_sif[0]), 32'd0);
    nop();
    cyc(); chk("t3_fwd_b_wb", 32'(smp_fb[0]), 32'd1);

    // Taken branch in IE coinciding with a load-use: flush wins.
    set_id(5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    set_id(5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
    pc_sel = 1'b1;
    cyc(); chk("t5_flush_id", 32'(smp_fid[0]), 32'd1);
           chk("t5_flush_ie", 32'(smp_fie[0]), 32'd1);
           chk("t5_no_stall", 32'(smp_sif[0]), 32'd0);
    pc_sel = 1'b0; nop();
    cyc(); cyc();
    cyc(); chk("t5_branch_commits", 32'(smp_cm[0]), 32'd1);
    cyc(); chk("t5_flushed_id", 32'(smp_cm[0]), 32'd0);
    cyc(); chk("t5_flushed_if", 32'(smp_cm[0]), 32'd0);

    // Reset with a full pipeline, then wrap the 4-bit counter.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc(); chk("t6_rst_count", smp_cnt[2], 32'd0);
           chk("t6_rst_commit", 32'(smp_cm[2]), 32'd0);
    for (int i = 0; i <= 20; i++) cyc();
    chk("t6_wrap", smp_cnt[2], 32'd1);
    chk("t6_count32", smp_cnt[0], 32'd17);

    // Randomized traffic on a small register window to provoke frequent hazards.
    for (int i = 0; i < 400; i++) begin
      rst_n  = ($urandom_range(0, 99) != 0);
      pc_sel = ($urandom_range(0, 9) == 0);
      set_id(5'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 3) == 0),
             5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom));
      cyc();
    end

    rst_n = 1'b0; pc_sel = 1'b0; nop();
    cyc();
    rst_n = 1'b1;
    cyc(); chk("t6_mid_rst_count", smp_cnt[0], 32'd0);
           chk("t6_mid_rst_commit", 32'(smp_cm[0]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
